// File: rtl/neuron_store_unit.sv
// neuron_store_unit
//   Packs serial 8-bit output activations from the PE array into 56-bit,
//   7-channel activation-cache words. A running channel pointer persists
//   across rows, so a word may be written in several byte-enabled pieces
//   when rows end mid-word.
//
//   Optional build macro: NEURON_STORE_RELU_EN
//     defined   -> negative (signed) activations are stored as 0x00
//     undefined -> activations are stored unmodified
//
// Ports
//   clk                  clock, rising edge
//   layer_reset          synchronous active-high reset
//   base_addr_i          start word address, sampled during layer_reset
//   neuron_activation_i  activation byte
//   neuron_valid_i       activation valid
//   row_last_i           current byte ends a row (forces a flush)
//   neuron_ready_o       block can accept a byte (COLLECT)
//   store_data_o         packed word, channel k in bits [8k+7:8k]
//   store_byte_en_o      per-channel write enable
//   store_addr_o         word address
//   store_valid_o        write request
//   store_ready_i        cache accepts the write
module neuron_store_unit #(
    parameter int FETCH_DATA_BIT_WIDTH = 56,
    parameter int REG_BIT_WIDTH        = 8,
    parameter int CACHE_CHANNELS       = 7,
    parameter int ADDR_BIT_WIDTH       = 10
) (
    input  logic                            clk,
    input  logic                            layer_reset,
    input  logic [ADDR_BIT_WIDTH-1:0]       base_addr_i,
    input  logic [REG_BIT_WIDTH-1:0]        neuron_activation_i,
    input  logic                            neuron_valid_i,
    input  logic                            row_last_i,
    output logic                            neuron_ready_o,
    output logic [FETCH_DATA_BIT_WIDTH-1:0] store_data_o,
    output logic [CACHE_CHANNELS-1:0]       store_byte_en_o,
    output logic [ADDR_BIT_WIDTH-1:0]       store_addr_o,
    output logic                            store_valid_o,
    input  logic                            store_ready_i
);

    typedef enum logic {COLLECT, WRITE} state_t;

    localparam logic [2:0] LAST_CH = 3'(CACHE_CHANNELS - 1);

    state_t                          state_q;
    logic [2:0]                      ptr_q,   ptr_d;
    logic [ADDR_BIT_WIDTH-1:0]       addr_q;
    logic [FETCH_DATA_BIT_WIDTH-1:0] buf_q,   buf_d;
    logic [CACHE_CHANNELS-1:0]       mask_q,  mask_d;
    logic [REG_BIT_WIDTH-1:0]        act_d;
    logic                            flush_d;

    // Registered outputs
    logic                            ready_q;
    logic                            valid_q;
    logic [FETCH_DATA_BIT_WIDTH-1:0] data_q;
    logic [CACHE_CHANNELS-1:0]       be_q;
    logic [ADDR_BIT_WIDTH-1:0]       oaddr_q;

    assign neuron_ready_o  = ready_q;
    assign store_valid_o   = valid_q;
    assign store_data_o    = data_q;
    assign store_byte_en_o = be_q;
    assign store_addr_o    = oaddr_q;

    // Next buffer/mask assuming the current byte is accepted; the flush
    // path loads these directly into the output registers so the write
    // request appears the cycle after the last byte.
    always_comb begin
`ifdef NEURON_STORE_RELU_EN
        act_d = neuron_activation_i[REG_BIT_WIDTH-1] ? '0 : neuron_activation_i;
`else
        act_d = neuron_activation_i;
`endif
        buf_d  = buf_q;
        mask_d = mask_q;
        for (int k = 0; k < CACHE_CHANNELS; k++) begin
            if (ptr_q == 3'(k)) begin
                buf_d[k*REG_BIT_WIDTH +: REG_BIT_WIDTH] = act_d;
                mask_d[k] = 1'b1;
            end
        end
        ptr_d   = (ptr_q == LAST_CH) ? 3'd0 : ptr_q + 3'd1;
        flush_d = row_last_i || (ptr_q == LAST_CH);
    end

    always_ff @(posedge clk) begin
        if (layer_reset) begin
            state_q <= COLLECT;
            ptr_q   <= '0;
            addr_q  <= base_addr_i;
            buf_q   <= '0;
            mask_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            be_q    <= '0;
            oaddr_q <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (neuron_valid_i && ready_q) begin
                        buf_q  <= buf_d;
                        mask_q <= mask_d;
                        ptr_q  <= ptr_d;
                        if (flush_d) begin
                            state_q <= WRITE;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            data_q  <= buf_d;
                            be_q    <= mask_d;
                            oaddr_q <= addr_q;
                        end
                    end
                end
                WRITE: begin
                    if (store_ready_i) begin
                        state_q <= COLLECT;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        be_q    <= '0;
                        buf_q   <= '0;
                        mask_q  <= '0;
                        // Only a word that reached the top channel is complete;
                        // partial pieces leave the address for the next row.
                        if (mask_q[CACHE_CHANNELS-1])
                            addr_q <= addr_q + ADDR_BIT_WIDTH'(1);
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule
